// File: rtl/inv_shift_sub_bytes_seq_if.sv
// Handshake bundle for the InvShiftRows + InvSubBytes stage.
//   in_valid/in_ready/in_state    : upstream state transfer (128-bit, FIPS-197 byte order)
//   out_valid/out_ready/out_state : downstream result transfer
// slave  : the stage itself
// master : the upstream/downstream driver (round controller or bench)
interface inv_shift_sub_bytes_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state
  );

  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state
  );
endinterface

// File: rtl/inv_shift_sub_bytes_seq.sv
// Sequential InvShiftRows + InvSubBytes stage for AES-128 decryption.
// InvShiftRows is applied as wiring when the state is captured; InvSubBytes
// then runs over 16/SBOX_PER_CYCLE cycles through SBOX_PER_CYCLE inverse
// S-box lanes, filling the result register a group of bytes at a time.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous reset, active low
//   bus   : slave side of the in/out valid-ready handshake bundle
//   busy  : high while a state is being substituted or held for output

// Combinational inverse S-box: undo the affine map, then GF(2^8) inverse.
module inv_sbox (
  input  logic [7:0] addr,
  output logic [7:0] dout
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 == x^-1 for x != 0, and maps 0 to 0 as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq, acc;
    sq  = x;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] pre;
  assign pre  = {addr[6:0], addr[7]} ^ {addr[4:0], addr[7:5]} ^
                {addr[1:0], addr[7:2]} ^ 8'h05;
  assign dout = gf_inv(pre);
endmodule

module inv_shift_sub_bytes_seq #(
  parameter int SBOX_PER_CYCLE = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  inv_shift_sub_bytes_seq_if.slave  bus,
  output logic                      busy
);
  localparam int N     = SBOX_PER_CYCLE;
  localparam int STEPS = 16 / N;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (!(N == 1 || N == 2 || N == 4 || N == 8 || N == 16)) begin : g_bad_param
    $error("SBOX_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [127:0]   work_q;
  logic [127:0]   result_q;
  logic           hs;

  // s'[r][c] = s[r][(c-r) mod 4]; byte i sits at bits 127-8i and is row i%4, col i/4
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        r[127-8*(rw+4*c) -: 8] = s[127-8*(rw+4*((c-rw+4)%4)) -: 8];
    return r;
  endfunction

  // lane j handles byte cnt*N+j; ~idx turns a byte number into its
  // little-endian byte slot (15-idx) inside the 128-bit vector
  logic [3:0]           base;
  logic [N-1:0][3:0]    lane_pos;
  logic [N-1:0][7:0]    sb_addr, sb_dout;

  assign base = 4'(int'(cnt_q) * N);

  for (genvar j = 0; j < N; j++) begin : g_lane
    assign lane_pos[j] = ~(base + 4'(j));
    assign sb_addr[j]  = work_q[{lane_pos[j], 3'b000} +: 8];
    inv_sbox u_sbox (.addr(sb_addr[j]), .dout(sb_dout[j]));
  end

  assign hs = bus.in_valid && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)     state_d = BUSY;
      BUSY:    if (cnt_q == LAST)    state_d = DONE;
      DONE:    if (bus.out_ready)    state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      work_q   <= '0;
      result_q <= '0;
    end else if (hs) begin
      work_q <= inv_shift_rows(bus.in_state);
      cnt_q  <= '0;
    end else if (state_q == BUSY) begin
      for (int j = 0; j < N; j++)
        result_q[{lane_pos[j], 3'b000} +: 8] <= sb_dout[j];
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // in_ready is gated by reset so it stays low while reset is held
  assign bus.in_ready  = (state_q == IDLE) && reset;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_state = result_q;
  assign busy          = (state_q != IDLE);
endmodule

// File: doc/inv_shift_sub_bytes_seq.md
Name: inv_shift_sub_bytes_seq

Overview:
Sequential InvShiftRows + InvSubBytes stage for the AES-128 decryption datapath. It accepts one 128-bit state over a valid/ready handshake and applies InvShiftRows, which is pure wiring at capture. It then runs InvSubBytes over several cycles through SBOX_PER_CYCLE time-multiplexed instances of the team's combinational inverse S-box (8-bit addr in, 8-bit dout out). The block feeds the AddRoundKey stage and trades area for latency compared with a 16-instance combinational InvSubBytes.

Parameters:
SBOX_PER_CYCLE, 4, number of inverse S-box instances and bytes substituted per cycle. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset
in_valid  input  1  in_state is valid
in_ready  output  1  block can accept a state
in_state  input  128  state; byte i = in_state[127-8i -: 8], row i%4, column i/4 (FIPS-197 column-major)
out_valid  output  1  out_state is valid
out_ready  input  1  downstream accepts out_state
out_state  output  128  InvSubBytes(InvShiftRows(in_state)), same byte ordering
busy  output  1  high in BUSY or DONE

Behaviour:
- Reset (reset=0, asynchronous): FSM goes to IDLE; in_ready=0 while reset is asserted, then 1 in IDLE; out_valid=0; busy=0; out_state=0; internal work and result registers = 0; byte counter = 0.
- Reset asserted mid-operation aborts the transaction. No partial output is ever presented.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On a handshake (in_valid & in_ready at a rising edge), the work register captures InvShiftRows(in_state): s'[r][c] = s[r][(c-r) mod 4].
  - Same edge: counter is cleared and the FSM moves to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle, bytes cnt*N .. cnt*N+N-1 of the work register (N=SBOX_PER_CYCLE, byte 0 = MSB) drive the N S-box addr inputs.
  - Their dout values are written into the same byte positions of the result register at the rising edge.
  - Counter increments and is sized to ceil(log2(16/N)) bits, minimum 1.
  - When cnt == 16/N-1, the FSM moves to DONE at that edge.
- DONE:
  - out_valid=1 and out_state = result register.
  - out_state and out_valid are held stable while out_ready=0, for any number of cycles.
  - in_ready=0: there is no input bypass in DONE.
  - On out_ready=1 at an edge, the FSM moves to IDLE and out_valid drops the next cycle.
- Latency: input handshake at edge k → out_valid high in the cycle after edge k+16/N. That is 4 edges for N=4 and 16 edges for N=1.
- Throughput: one state per 16/N+2 cycles when out_ready is held at 1.
- out_state comes directly from the result register, so the output path has no combinational logic. Result bytes not yet written are never visible, because out_valid only asserts in DONE.
- in_state and in_valid are ignored outside IDLE. Changes to in_state after capture do not affect the result.
- out_ready is ignored outside DONE.
- All registers other than the FSM hold their value when not being written. No X is allowed on any output after reset.

Test Plan:
- Reset check: reset=0 for 3 cycles, then release → out_valid=0, busy=0, out_state=0; in_ready=1 on the first cycle after release.
- Constant pattern: in_state=0x6363…63 accepted, out_ready=1 → out_valid after 4 edges with out_state=0x000…0, then IDLE on the next cycle. Repeat with 0x00…00 → 0x5252…52.
- Ordering check: in_state=0x000102030405060708090a0b0c0d0e0f → out_state=0x52f3a3383009d79ebf366afb8140a5d5.
- Backpressure: out_ready=0 for 10 cycles in DONE → out_valid and out_state stable and in_ready=0; in_valid pulsed during this window is not accepted. Raising out_ready completes the transfer in exactly one cycle.
- Mid-operation reset and corner values: reset pulsed at cnt=2 → immediate IDLE, out_valid never asserts, and the next 0x63-pattern transfer is correct. Back-to-back transfers with out_ready=1 → 6-cycle spacing between handshakes.
- Parameter sweep: SBOX_PER_CYCLE=1 and 16 give the ordering-check result, with latencies of 16 and 1 edges respectively.
